svc_rv_btb: RTL and testbench

SVC_RV_BTB -- requirements
Module: svc_rv_btb

---
 rtl/svc_rv_btb_pkg.sv | 33 +++
 rtl/svc_rv_btb.sv | 165 ++++++++++++++++
 tb/tb_svc_rv_btb.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/svc_rv_btb_pkg.sv
// svc_rv_btb_pkg: shared types and helpers for the branch target buffer.
// The entry struct is sized for the widest supported configuration
// (64-bit addresses, 8-bit counters). The BTB uses only the low bits
// of each field for its own XLEN/CNT_W. Any upper bits it never reads
// are removed by synthesis.
package svc_rv_btb_pkg;

  localparam int BTB_ADDR_MAX = 64;
  localparam int BTB_CNT_MAX  = 8;

  typedef struct packed {
    logic                    valid;
    logic [BTB_ADDR_MAX-1:0] tag;
    logic [BTB_ADDR_MAX-1:0] target;
    logic [BTB_CNT_MAX-1:0]  cnt;
  } btb_entry_t;

  // Saturating up/down step of a cnt_w-bit direction counter.
  function automatic logic [BTB_CNT_MAX-1:0] sat_cnt_update(
    input logic [BTB_CNT_MAX-1:0] cnt,
    input logic                   inc,
    input int                     cnt_w
  );
    logic [BTB_CNT_MAX-1:0] cnt_max;
    cnt_max = BTB_CNT_MAX'((64'd1 << cnt_w) - 64'd1);
    if (inc) begin
      return (cnt >= cnt_max) ? cnt_max : cnt + 1'b1;
    end else begin
      return (cnt == '0) ? '0 : cnt - 1'b1;
    end
  endfunction

endpackage

// File: rtl/svc_rv_btb.sv
// svc_rv_btb: direct-mapped branch target buffer with registered lookup,
// saturating direction counters and whole-table flush.
// Optional feature: define SVC_RV_BTB_STATS_EN to build the 32-bit
// lookup/hit/mispredict performance counters. Without it the stat_*
// ports read constant zero.
module svc_rv_btb
  import svc_rv_btb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lu_valid,
  input  logic [XLEN-1:0] lu_pc,
  output logic            pred_valid,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_mispred,
  input  logic            flush,
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_hits,
  output logic [31:0]     stat_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [BTB_CNT_MAX-1:0] CNT_INIT = BTB_CNT_MAX'(1) << (CNT_W - 1);

  // Address split; pc[1:0] never takes part in indexing or tag compare.
  logic [IDX_W-1:0] lu_idx;
  logic [TAG_W-1:0] lu_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;

  assign lu_idx  = lu_pc[IDX_W+1:2];
  assign lu_tag  = lu_pc[XLEN-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[XLEN-1:IDX_W+2];

  btb_entry_t table_q [ENTRIES];
  btb_entry_t table_d [ENTRIES];

  btb_entry_t lu_ent;
  btb_entry_t upd_ent;
  logic       lu_hit;
  logic       upd_hit;

  logic            pred_vld_p1_d,    pred_vld_p1_q;
  logic            pred_hit_p1_d,    pred_hit_p1_q;
  logic            pred_taken_p1_d,  pred_taken_p1_q;
  logic [XLEN-1:0] pred_target_p1_d, pred_target_p1_q;

  // Stage p0: read the table as it stands before this edge's update/flush.
  always_comb begin
    lu_ent           = table_q[lu_idx];
    lu_hit           = lu_ent.valid && (lu_ent.tag[TAG_W-1:0] == lu_tag);
    pred_vld_p1_d    = lu_valid;
    pred_hit_p1_d    = lu_valid && lu_hit;
    pred_taken_p1_d  = pred_hit_p1_d && lu_ent.cnt[CNT_W-1];
    pred_target_p1_d = pred_hit_p1_d ? lu_ent.target[XLEN-1:0] : '0;
  end

  // Next table state: flush wins over update; only valid bits are cleared.
  always_comb begin
    table_d = table_q;
    upd_ent = table_q[upd_idx];
    upd_hit = upd_ent.valid && (upd_ent.tag[TAG_W-1:0] == upd_tag);
    if (flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_d[i].valid = 1'b0;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        table_d[upd_idx].cnt = sat_cnt_update(upd_ent.cnt, upd_taken, CNT_W);
        if (upd_taken) begin
          table_d[upd_idx].target = BTB_ADDR_MAX'(upd_target);
        end
      end else if (upd_taken) begin
        table_d[upd_idx].valid  = 1'b1;
        table_d[upd_idx].tag    = BTB_ADDR_MAX'(upd_tag);
        table_d[upd_idx].target = BTB_ADDR_MAX'(upd_target);
        table_d[upd_idx].cnt    = CNT_INIT;
      end
    end
  end

  // Table registers: reset clears only the valid bits, payload holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i].valid <= 1'b0;
      end
    end else begin
      table_q <= table_d;
    end
  end

  // Stage p1: registered prediction outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_vld_p1_q    <= 1'b0;
      pred_hit_p1_q    <= 1'b0;
      pred_taken_p1_q  <= 1'b0;
      pred_target_p1_q <= '0;
    end else begin
      pred_vld_p1_q    <= pred_vld_p1_d;
      pred_hit_p1_q    <= pred_hit_p1_d;
      pred_taken_p1_q  <= pred_taken_p1_d;
      pred_target_p1_q <= pred_target_p1_d;
    end
  end

  assign pred_valid  = pred_vld_p1_q;
  assign pred_hit    = pred_hit_p1_q;
  assign pred_taken  = pred_taken_p1_q;
  assign pred_target = pred_target_p1_q;

`ifdef SVC_RV_BTB_STATS_EN
  logic [31:0] stat_lookups_d, stat_lookups_q;
  logic [31:0] stat_hits_d,    stat_hits_q;
  logic [31:0] stat_mispred_d, stat_mispred_q;

  // Free-running event counters; they wrap and are not touched by flush.
  always_comb begin
    stat_lookups_d = stat_lookups_q + 32'(lu_valid);
    stat_hits_d    = stat_hits_q + 32'(pred_vld_p1_q && pred_hit_p1_q);
    stat_mispred_d = stat_mispred_q + 32'(upd_valid && upd_mispred);
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_lookups_q <= '0;
      stat_hits_q    <= '0;
      stat_mispred_q <= '0;
    end else begin
      stat_lookups_q <= stat_lookups_d;
      stat_hits_q    <= stat_hits_d;
      stat_mispred_q <= stat_mispred_d;
    end
  end

  assign stat_lookups = stat_lookups_q;
  assign stat_hits    = stat_hits_q;
  assign stat_mispred = stat_mispred_q;
`else
  logic unused_stat;
  assign unused_stat  = upd_mispred;
  assign stat_lookups = '0;
  assign stat_hits    = '0;
  assign stat_mispred = '0;
`endif

  // Ignored PC byte-offset bits and the wide-struct headroom bits.
  logic unused_bits;
  assign unused_bits = ^{lu_pc[1:0], upd_pc[1:0], lu_ent, upd_ent};

endmodule

// File: tb/tb_svc_rv_btb.sv
// tb_svc_rv_btb: directed, table-driven bench for svc_rv_btb at default
// parameters (XLEN=32, ENTRIES=16, CNT_W=2). Build with or without
// SVC_RV_BTB_STATS_EN; the expected stat values follow the macro.
module tb_svc_rv_btb;

  logic        clk = 1'b0;
  logic        rst;
  logic        lu_valid;
  logic [31:0] lu_pc;
  logic        pred_valid, pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispred;
  logic        flush;
  logic [31:0] stat_lookups, stat_hits, stat_mispred;

  int n_tests = 0;
  int n_fail  = 0;

  svc_rv_btb dut (
    .clk(clk), .rst(rst),
    .lu_valid(lu_valid), .lu_pc(lu_pc),
    .pred_valid(pred_valid), .pred_hit(pred_hit),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispred(upd_mispred),
    .flush(flush),
    .stat_lookups(stat_lookups), .stat_hits(stat_hits),
    .stat_mispred(stat_mispred)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          lu;
    logic [31:0] lpc;
    bit          up;
    logic [31:0] upc;
    bit          tk;
    logic [31:0] tgt;
    bit          fl;
    bit          ev;
    bit          eh;
    bit          et;
    logic [31:0] etg;
  } vec_t;

  vec_t vecs[$];

  // One cycle of stimulus: drive at negedge, return 1 after the posedge.
  task automatic drive(input bit lu, input logic [31:0] lpc, input bit up,
                       input logic [31:0] upc, input bit tk, input logic [31:0] tgt,
                       input bit mis, input bit fl);
    @(negedge clk);
    lu_valid    = lu;
    lu_pc       = lpc;
    upd_valid   = up;
    upd_pc      = upc;
    upd_taken   = tk;
    upd_target  = tgt;
    upd_mispred = mis;
    flush       = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic check_pred(input string name, input bit ev, input bit eh,
                            input bit et, input logic [31:0] etg);
    n_tests++;
    if (pred_valid !== ev || pred_hit !== eh || pred_taken !== et || pred_target !== etg) begin
      n_fail++;
      $display("FAIL %s: got v=%0b h=%0b t=%0b tgt=%h, want v=%0b h=%0b t=%0b tgt=%h",
               name, pred_valid, pred_hit, pred_taken, pred_target, ev, eh, et, etg);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_lk, exp_ht, exp_mp;
`ifdef SVC_RV_BTB_STATS_EN
    exp_lk = 32'd10; exp_ht = 32'd6; exp_mp = 32'd3;
`else
    exp_lk = 32'd0;  exp_ht = 32'd0; exp_mp = 32'd0;
`endif

    //            name           lu lpc      up upc      tk tgt      fl  ev eh et etg
    vecs.push_back('{"cold_miss",    1, 'h100, 0, 'h000, 0, 'h00, 0, 1, 0, 0, 'h00});
    vecs.push_back('{"alloc_100",    0, 'h000, 1, 'h100, 1, 'h80, 0, 0, 0, 0, 'h00});
    vecs.push_back('{"hit_100",      1, 'h100, 0, 'h000, 0, 'h00, 0, 1, 1, 1, 'h80});
    vecs.push_back('{"same_cyc_nt",  1, 'h100, 1, 'h100, 0, 'h00, 0, 1, 1, 1, 'h80});
    vecs.push_back('{"cnt1_nt",      1, 'h100, 0, 'h000, 0, 'h00, 0, 1, 1, 0, 'h80});
    vecs.push_back('{"nt2",          0, 'h000, 1, 'h100, 0, 'h00, 0, 0, 0, 0, 'h00});
    vecs.push_back('{"cnt0",         1, 'h100, 0, 'h000, 0, 'h00, 0, 1, 1, 0, 'h80});
    vecs.push_back('{"t_newtgt",     0, 'h000, 1, 'h100, 1, 'h90, 0, 0, 0, 0, 'h00});
    vecs.push_back('{"cnt0_sat_lo",  1, 'h100, 0, 'h000, 0, 'h00, 0, 1, 1, 0, 'h90});
    vecs.push_back('{"sat_t1",       0, 'h000, 1, 'h100, 1, 'h90, 0, 0, 0, 0, 'h00});
    vecs.push_back('{"sat_t2",       0, 'h000, 1, 'h100, 1, 'h90, 0, 0, 0, 0, 'h00});
    vecs.push_back('{"sat_t3",       0, 'h000, 1, 'h100, 1, 'h90, 0, 0, 0, 0, 'h00});
    vecs.push_back('{"sat_nt",       0, 'h000, 1, 'h100, 0, 'h00, 0, 0, 0, 0, 'h00});
    vecs.push_back('{"sat_hi_chk",   1, 'h100, 0, 'h000, 0, 'h00, 0, 1, 1, 1, 'h90});
    vecs.push_back('{"nt_miss_200",  0, 'h000, 1, 'h200, 0, 'h00, 0, 0, 0, 0, 'h00});
    vecs.push_back('{"no_alloc_200", 1, 'h200, 0, 'h000, 0, 'h00, 0, 1, 0, 0, 'h00});
    vecs.push_back('{"keep_100",     1, 'h100, 0, 'h000, 0, 'h00, 0, 1, 1, 1, 'h90});
    vecs.push_back('{"alloc_140",    0, 'h000, 1, 'h140, 1, 'hC0, 0, 0, 0, 0, 'h00});
    vecs.push_back('{"alias_100",    1, 'h100, 0, 'h000, 0, 'h00, 0, 1, 0, 0, 'h00});
    vecs.push_back('{"alias_140",    1, 'h140, 0, 'h000, 0, 'h00, 0, 1, 1, 1, 'hC0});
    vecs.push_back('{"lowbits_143",  1, 'h143, 0, 'h000, 0, 'h00, 0, 1, 1, 1, 'hC0});
    vecs.push_back('{"same_cyc_300", 1, 'h300, 1, 'h300, 1, 'h44, 0, 1, 0, 0, 'h00});
    vecs.push_back('{"next_300",     1, 'h300, 0, 'h000, 0, 'h00, 0, 1, 1, 1, 'h44});
    vecs.push_back('{"alloc_104",    0, 'h000, 1, 'h104, 1, 'h10, 0, 0, 0, 0, 'h00});
    vecs.push_back('{"alloc_108",    0, 'h000, 1, 'h108, 1, 'h20, 0, 0, 0, 0, 'h00});
    vecs.push_back('{"alloc_10c",    0, 'h000, 1, 'h10C, 1, 'h30, 0, 0, 0, 0, 'h00});
    vecs.push_back('{"hit_108",      1, 'h108, 0, 'h000, 0, 'h00, 0, 1, 1, 1, 'h20});
    vecs.push_back('{"flush_cyc",    1, 'h104, 1, 'h400, 1, 'h50, 1, 1, 1, 1, 'h10});
    vecs.push_back('{"fl_104",       1, 'h104, 0, 'h000, 0, 'h00, 0, 1, 0, 0, 'h00});
    vecs.push_back('{"fl_108",       1, 'h108, 0, 'h000, 0, 'h00, 0, 1, 0, 0, 'h00});
    vecs.push_back('{"fl_10c",       1, 'h10C, 0, 'h000, 0, 'h00, 0, 1, 0, 0, 'h00});
    vecs.push_back('{"fl_300",       1, 'h300, 0, 'h000, 0, 'h00, 0, 1, 0, 0, 'h00});
    vecs.push_back('{"fl_400",       1, 'h400, 0, 'h000, 0, 'h00, 0, 1, 0, 0, 'h00});

    // Reset state
    rst = 1'b1; lu_valid = 0; lu_pc = 0; upd_valid = 0; upd_pc = 0;
    upd_taken = 0; upd_target = 0; upd_mispred = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    check_pred("reset_pred", 0, 0, 0, 32'h0);
    check32("reset_lookups", stat_lookups, 32'd0);
    check32("reset_hits", stat_hits, 32'd0);
    check32("reset_mispred", stat_mispred, 32'd0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_pred("post_reset_idle", 0, 0, 0, 32'h0);

    // Main vector table
    foreach (vecs[i]) begin
      drive(vecs[i].lu, vecs[i].lpc, vecs[i].up, vecs[i].upc, vecs[i].tk,
            vecs[i].tgt, 1'b0, vecs[i].fl);
      check_pred(vecs[i].name, vecs[i].ev, vecs[i].eh, vecs[i].et, vecs[i].etg);
    end

    // Reset discards same-cycle lookup/update and clears valid bits
    drive(0, 0, 1, 'h500, 1, 'h60, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    lu_valid = 1; lu_pc = 'h500;
    upd_valid = 1; upd_pc = 'h504; upd_taken = 1; upd_target = 'h70;
    @(posedge clk);
    #1;
    check_pred("rst_cycle", 0, 0, 0, 32'h0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_pred("rst_release", 0, 0, 0, 32'h0);
    check32("rst_stat_lookups", stat_lookups, 32'd0);
    drive(1, 'h500, 0, 0, 0, 0, 0, 0);
    check_pred("rst_clr_valid", 1, 0, 0, 32'h0);
    drive(1, 'h504, 0, 0, 0, 0, 0, 0);
    check_pred("rst_drop_upd", 1, 0, 0, 32'h0);

    // Performance counters: 3 mispredicted updates, 10 lookups with 6 hits
    @(negedge clk);
    rst = 1'b1; lu_valid = 0; upd_valid = 0; flush = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 0, 1, 'h600, 1, 'h11, 1, 0);
    drive(0, 0, 1, 'h604, 1, 'h22, 1, 0);
    drive(0, 0, 1, 'h608, 0, 'h00, 1, 0);
    for (int i = 0; i < 6; i++) begin
      drive(1, (i % 2 == 0) ? 32'h600 : 32'h604, 0, 0, 0, 0, 0, 0);
      check_pred("stat_hit_lu", 1, 1, 1, (i % 2 == 0) ? 32'h11 : 32'h22);
    end
    drive(1, 'h608, 0, 0, 0, 0, 0, 0);
    drive(1, 'h60C, 0, 0, 0, 0, 0, 0);
    drive(1, 'h700, 0, 0, 0, 0, 0, 0);
    drive(1, 'h608, 0, 0, 0, 0, 0, 0);
    check_pred("stat_miss_lu", 1, 0, 0, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check32("stat_lookups", stat_lookups, exp_lk);
    check32("stat_hits", stat_hits, exp_ht);
    check32("stat_mispred", stat_mispred, exp_mp);

    // Flush leaves the counters alone
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    check32("flush_keeps_lookups", stat_lookups, exp_lk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
